// File: rtl/boss_pkg.sv
// boss_pkg: shared state/direction types and default arena geometry for the boss mover
package boss_pkg;
    localparam int SCREEN_W        = 800;
    localparam int SCREEN_H        = 480;
    localparam int BOSS_H          = 44;
    localparam int BOSS_MARGIN     = 100;
    localparam int DEF_COORD_W     = 12;
    localparam int DEF_GROUND_Y    = SCREEN_H - BOSS_H;
    localparam int DEF_JUMP_HEIGHT = 350;
    localparam int DEF_RISE_SPEED  = 9;
    localparam int DEF_FALL_SPEED  = 9;
    localparam int DEF_MOVE_STEP   = 5;
    localparam int DEF_WAIT_TICKS  = 30;
    localparam int DEF_X_MIN       = BOSS_MARGIN;
    localparam int DEF_X_MAX       = SCREEN_W - BOSS_MARGIN;
    localparam int DEF_START_X     = 600;

    typedef enum logic [1:0] {
        WAIT = 2'd0,
        RISE = 2'd1,
        FALL = 2'd2
    } boss_state_t;

    typedef enum logic [1:0] {
        NONE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } boss_dir_t;
endpackage

// File: rtl/boss_target_sel.sv
// boss_target_sel: combinational argmax over player aggro, ties resolved to the lowest index
module boss_target_sel #(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = 12
) (
    input  logic [NUM_PLAYERS-1:0][COORD_W-1:0] player_x,
    input  logic [NUM_PLAYERS-1:0][3:0]         player_aggro,
    output logic [COORD_W-1:0]                  target_x
);
    logic [3:0] best;

    // strict greater-than keeps the earliest player on equal aggro
    always_comb begin
        best     = player_aggro[0];
        target_x = player_x[0];
        for (int i = 1; i < NUM_PLAYERS; i++) begin
            if (player_aggro[i] > best) begin
                best     = player_aggro[i];
                target_x = player_x[i];
            end
        end
    end
endmodule

// File: rtl/boss_motion_ctrl.sv
// boss_motion_ctrl: aggro-targeted WAIT/RISE/FALL jumping boss mover; define BOSS_ENRAGE_EN for enrage speed-up
module boss_motion_ctrl
    import boss_pkg::*;
#(
    parameter int NUM_PLAYERS = 2,
    parameter int COORD_W     = DEF_COORD_W,
    parameter int GROUND_Y    = DEF_GROUND_Y,
    parameter int JUMP_HEIGHT = DEF_JUMP_HEIGHT,
    parameter int RISE_SPEED  = DEF_RISE_SPEED,
    parameter int FALL_SPEED  = DEF_FALL_SPEED,
    parameter int MOVE_STEP   = DEF_MOVE_STEP,
    parameter int WAIT_TICKS  = DEF_WAIT_TICKS,
    parameter int X_MIN       = DEF_X_MIN,
    parameter int X_MAX       = DEF_X_MAX,
    parameter int START_X     = DEF_START_X
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                frame_tick,
    input  logic [1:0]                          game_active,
    input  logic [NUM_PLAYERS-1:0][COORD_W-1:0] player_x,
    input  logic [NUM_PLAYERS-1:0][3:0]         player_aggro,
    input  logic                                enrage,
    output logic [COORD_W-1:0]                  boss_x,
    output logic [COORD_W-1:0]                  boss_y,
    output boss_state_t                         boss_state,
    output logic                                landed
);
    localparam int PEAK = GROUND_Y - JUMP_HEIGHT;
    localparam int CW   = $clog2(WAIT_TICKS + 2);
    localparam int XW   = COORD_W + 1;

    logic [COORD_W-1:0] target_x;
    boss_state_t        state_nxt;
    boss_dir_t          dir, dir_nxt;
    logic [CW-1:0]      cnt, cnt_nxt, reload;
    logic [COORD_W-1:0] x_nxt, y_nxt, x_left, x_right;
    logic [XW-1:0]      step, x_ext, y_ext;
    logic               landed_nxt, run, rise_more, fall_more;

    boss_target_sel #(
        .NUM_PLAYERS(NUM_PLAYERS),
        .COORD_W    (COORD_W)
    ) u_sel (
        .player_x    (player_x),
        .player_aggro(player_aggro),
        .target_x    (target_x)
    );

    assign run = frame_tick && game_active == 2'd1;

`ifdef BOSS_ENRAGE_EN
    assign step   = enrage ? XW'(2 * MOVE_STEP) : XW'(MOVE_STEP);
    assign reload = enrage ? CW'(WAIT_TICKS / 2) : CW'(WAIT_TICKS);
`else
    logic unused_enrage;
    assign unused_enrage = enrage;
    assign step   = XW'(MOVE_STEP);
    assign reload = CW'(WAIT_TICKS);
`endif

    assign x_ext     = {1'b0, boss_x};
    assign y_ext     = {1'b0, boss_y};
    assign rise_more = y_ext > XW'(PEAK + RISE_SPEED);
    assign fall_more = y_ext + XW'(FALL_SPEED) < XW'(GROUND_Y);
    assign x_left    = (x_ext < XW'(X_MIN) + step) ? COORD_W'(X_MIN) : COORD_W'(x_ext - step);
    assign x_right   = (x_ext + step > XW'(X_MAX)) ? COORD_W'(X_MAX) : COORD_W'(x_ext + step);

    // state and datapath registers; game_active==0 acts as a second synchronous reset
    always_ff @(posedge clk) begin
        if (rst || game_active == 2'd0) begin
            boss_state <= WAIT;
            dir        <= NONE;
            cnt        <= '0;
            boss_x     <= COORD_W'(START_X);
            boss_y     <= COORD_W'(GROUND_Y);
            landed     <= 1'b0;
        end else begin
            boss_state <= state_nxt;
            dir        <= dir_nxt;
            cnt        <= cnt_nxt;
            boss_x     <= x_nxt;
            boss_y     <= y_nxt;
            landed     <= landed_nxt;
        end
    end

    // phase transitions: takeoff when the pause expires, apex and touchdown by y limits
    always_comb begin
        state_nxt = boss_state;
        if (run) begin
            case (boss_state)
                WAIT:    state_nxt = (cnt == '0) ? RISE : WAIT;
                RISE:    state_nxt = rise_more ? RISE : FALL;
                FALL:    state_nxt = fall_more ? FALL : WAIT;
                default: state_nxt = WAIT;
            endcase
        end
    end

    // per-tick motion: pause countdown, direction latch at takeoff, y profile, clamped x travel
    always_comb begin
        dir_nxt    = dir;
        cnt_nxt    = cnt;
        x_nxt      = boss_x;
        y_nxt      = boss_y;
        landed_nxt = 1'b0;
        if (run) begin
            case (boss_state)
                WAIT: begin
                    if (cnt != '0)
                        cnt_nxt = cnt - CW'(1);
                    else
                        dir_nxt = (target_x < boss_x) ? LEFT : (target_x > boss_x) ? RIGHT : NONE;
                end
                RISE: y_nxt = rise_more ? boss_y - COORD_W'(RISE_SPEED) : COORD_W'(PEAK);
                FALL: begin
                    y_nxt      = fall_more ? boss_y + COORD_W'(FALL_SPEED) : COORD_W'(GROUND_Y);
                    landed_nxt = !fall_more;
                    cnt_nxt    = fall_more ? cnt : reload;
                end
                default: ;
            endcase
            if (boss_state != WAIT)
                x_nxt = (dir == LEFT) ? x_left : (dir == RIGHT) ? x_right : boss_x;
        end
    end
endmodule

// File: tb/tb_boss_motion_ctrl.sv
// tb_boss_motion_ctrl: directed and randomized checks of boss_motion_ctrl against a behavioural jump model
module tb_boss_motion_ctrl;
    import boss_pkg::*;

    localparam int NP   = 2;
    localparam int CWD  = 12;
    localparam int G    = 436;
    localparam int PK   = 86;
    localparam int RS   = 9;
    localparam int FS   = 9;
    localparam int MS   = 5;
    localparam int WT   = 30;
    localparam int XMIN = 100;
    localparam int XMAX = 700;
    localparam int SX   = 600;
`ifdef BOSS_ENRAGE_EN
    localparam bit ENR_EN = 1'b1;
`else
    localparam bit ENR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst, frame_tick, enrage;
    logic [1:0] game_active;
    logic [NP-1:0][CWD-1:0] player_x;
    logic [NP-1:0][3:0] player_aggro;
    logic [CWD-1:0] boss_x, boss_y;
    boss_state_t boss_state;
    logic landed;

    int tests = 0;
    int fails = 0;
    int m_x, m_y, m_ph, m_cnt, m_dir;
    bit m_landed;

    always #5 clk = ~clk;

    boss_motion_ctrl #(.NUM_PLAYERS(NP), .COORD_W(CWD)) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .game_active (game_active),
        .player_x    (player_x),
        .player_aggro(player_aggro),
        .enrage      (enrage),
        .boss_x      (boss_x),
        .boss_y      (boss_y),
        .boss_state  (boss_state),
        .landed      (landed)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int tgt();
        int b = 0;
        for (int i = 1; i < NP; i++)
            if (player_aggro[i] > player_aggro[b]) b = i;
        return int'(player_x[b]);
    endfunction

    // jump rules in plain integer arithmetic; phase 0 = on ground, 1 = going up, 2 = coming down
    task automatic model_edge();
        int step, t;
        m_landed = 1'b0;
        step = (ENR_EN && enrage) ? 2 * MS : MS;
        if (rst || game_active == 2'd0) begin
            m_x = SX; m_y = G; m_ph = 0; m_cnt = 0; m_dir = 0;
        end else if (game_active == 2'd1 && frame_tick) begin
            if (m_ph == 0) begin
                if (m_cnt > 0) m_cnt--;
                else begin
                    t = tgt();
                    m_dir = (t < m_x) ? -1 : (t > m_x) ? 1 : 0;
                    m_ph = 1;
                end
            end else begin
                if (m_ph == 1) begin
                    if (m_y - RS > PK) m_y -= RS;
                    else begin m_y = PK; m_ph = 2; end
                end else begin
                    if (m_y + FS < G) m_y += FS;
                    else begin
                        m_y = G; m_ph = 0; m_landed = 1'b1;
                        m_cnt = (ENR_EN && enrage) ? WT / 2 : WT;
                    end
                end
                m_x = m_x + m_dir * step;
                if (m_x < XMIN) m_x = XMIN;
                if (m_x > XMAX) m_x = XMAX;
            end
        end
    endtask

    task automatic cyc(input bit t);
        @(negedge clk);
        frame_tick = t;
        @(posedge clk);
        model_edge();
        #1;
        chk("boss_x", 32'(boss_x), m_x);
        chk("boss_y", 32'(boss_y), m_y);
        chk("boss_state", 32'(boss_state), m_ph);
        chk("landed", 32'(landed), 32'(m_landed));
    endtask

    task automatic tick();
        cyc(1'b0);
        cyc(1'b1);
    endtask

    task automatic hold_reset();
        game_active = 2'd0;
        cyc(1'b1);
        game_active = 2'd1;
    endtask

    task automatic set_players(input int x0, input int x1, input int a0, input int a1);
        player_x[0] = CWD'(x0);
        player_x[1] = CWD'(x1);
        player_aggro[0] = 4'(a0);
        player_aggro[1] = 4'(a1);
    endtask

    initial begin
        int first, second;
        boss_state_t pv;
        rst = 1'b1; frame_tick = 1'b0; enrage = 1'b0; game_active = 2'd0;
        set_players(200, 500, 5, 3);
        cyc(1'b0);
        chk("reset_x", 32'(boss_x), SX);
        chk("reset_y", 32'(boss_y), G);
        chk("reset_state", 32'(boss_state), 0);
        rst = 1'b0; game_active = 2'd1;

        for (int k = 1; k <= 79; k++) begin
            tick();
            if (k == 1) begin
                chk("takeoff_state", 32'(boss_state), 1);
                chk("takeoff_x", 32'(boss_x), SX);
            end
            if (k == 40) chk("peak_y", 32'(boss_y), PK);
            if (k == 79) begin
                chk("land_pulse", 32'(landed), 1);
                chk("land_x", 32'(boss_x), 210);
                chk("land_y", 32'(boss_y), G);
            end
        end
        cyc(1'b0);
        chk("land_one_clk", 32'(landed), 0);

        hold_reset();
        set_players(150, 800, 0, 9);
        for (int k = 1; k <= 79; k++) begin
            tick();
            if (k == 21) chk("sat_x_reached", 32'(boss_x), XMAX);
            if (k == 79) begin
                chk("sat_x_land", 32'(boss_x), XMAX);
                chk("sat_land", 32'(landed), 1);
            end
        end

        hold_reset();
        set_players(600, 100, 9, 0);
        for (int k = 1; k <= 79; k++) begin
            tick();
            if (k == 40 || k == 79) chk("none_x", 32'(boss_x), SX);
        end

        hold_reset();
        set_players(150, 650, 7, 7);
        tick();
        tick();
        chk("tie_left_x", 32'(boss_x), SX - MS);

        hold_reset();
        set_players(200, 500, 5, 3);
        for (int k = 1; k <= 10; k++) tick();
        for (int k = 0; k < 50; k++) begin
            game_active = (k < 25) ? 2'd2 : 2'd3;
            tick();
        end
        chk("frozen_x", 32'(boss_x), 555);
        chk("frozen_y", 32'(boss_y), 355);
        chk("frozen_state", 32'(boss_state), 1);
        game_active = 2'd0;
        cyc(1'b0);
        chk("hold_x", 32'(boss_x), SX);
        chk("hold_y", 32'(boss_y), G);
        chk("hold_state", 32'(boss_state), 0);
        game_active = 2'd1;

        hold_reset();
        enrage = 1'b1;
        first = -1; second = -1;
        for (int k = 1; k <= 300 && second < 0; k++) begin
            pv = boss_state;
            tick();
            if (pv == WAIT && boss_state == RISE) begin
                if (first < 0) first = k;
                else second = k;
            end
        end
        chk("first_takeoff", first, 1);
        chk("period", second - first, ENR_EN ? 94 : 109);
        enrage = 1'b0;

        for (int k = 0; k < 3000; k++) begin
            rst = ($urandom_range(0, 199) == 0);
            game_active = ($urandom_range(0, 19) == 0) ? 2'($urandom_range(0, 3)) : 2'd1;
            if ($urandom_range(0, 99) == 0) enrage = ~enrage;
            if ($urandom_range(0, 39) == 0)
                set_players($urandom_range(0, 900), $urandom_range(0, 900),
                            $urandom_range(0, 15), $urandom_range(0, 15));
            cyc(1'($urandom_range(0, 1)));
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
